box_overlay_nch: RTL and testbench

Parametrised N-channel rectangle overlay for the video track path. It sits after target detection and before the output formatter. Each box has a per-frame-stable coordinate set, a colour and a configurable outline thickness. It draws outlines over the incoming 24-bit pixel stream with fixed latency and reports which boxes were actually rendered in the previous frame.

---
 rtl/overlay_pkg.sv | 23 ++
 rtl/box_edge_hit.sv | 51 +++++
 rtl/box_overlay_nch.sv | 174 +++++++++++++++++
 tb/tb_box_overlay_nch.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/overlay_pkg.sv
// rtl/overlay_pkg.sv - shared types, colours and blend helper for box_overlay_nch
// Contents: box_coord_t {up, down, left, right}, colour constants, blend50().
package overlay_pkg;

    localparam int COORD_W = 12;

    typedef struct packed {
        logic [COORD_W-1:0] up;
        logic [COORD_W-1:0] down;
        logic [COORD_W-1:0] left;
        logic [COORD_W-1:0] right;
    } box_coord_t;

    localparam logic [23:0] WHITE  = 24'hFFFFFF;
    localparam logic [23:0] RED    = 24'hFF0000;
    localparam logic [23:0] YELLOW = 24'hFFFF00;

    // 50/50 mix; each channel is halved before the add so no channel carries into the next.
    function automatic logic [23:0] blend50(input logic [23:0] a, input logic [23:0] b);
        return ((a >> 1) & 24'h7F7F7F) + ((b >> 1) & 24'h7F7F7F);
    endfunction

endpackage

// File: rtl/box_edge_hit.sv
// rtl/box_edge_hit.sv - per-box outline / interior comparators
// Ports: valid, up/down/left/right, x/y (current pixel) in;
//        outline_hit (on the THICK-wide border), inner_hit (strictly inside border) out.
// Both outputs are forced low when the box geometry is not drawable.
module box_edge_hit
    import overlay_pkg::*;
#(
    parameter int CW        = 12,
    parameter int IMG_HDISP = 1280,
    parameter int IMG_VDISP = 720,
    parameter int THICK     = 1
) (
    input  logic          valid,
    input  logic [CW-1:0] up,
    input  logic [CW-1:0] down,
    input  logic [CW-1:0] left,
    input  logic [CW-1:0] right,
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    output logic          outline_hit,
    output logic          inner_hit
);

    localparam logic [CW:0] H_MAX = (CW+1)'(IMG_HDISP);
    localparam logic [CW:0] V_MAX = (CW+1)'(IMG_VDISP);
    localparam logic [CW:0] TK    = (CW+1)'(THICK);

    // One extra bit so that edge+THICK never wraps.
    logic [CW:0] xe, ye, ue, de, le, re;
    logic        active, in_outer, in_inner;

    assign xe = {1'b0, x};
    assign ye = {1'b0, y};
    assign ue = {1'b0, up};
    assign de = {1'b0, down};
    assign le = {1'b0, left};
    assign re = {1'b0, right};

    assign active = valid && (ue <= de) && (le <= re) && (re < H_MAX) && (de < V_MAX);

    assign in_outer = (xe >= le) && (xe <= re) && (ye >= ue) && (ye <= de);

    // Inner rect tested as x+T <= right instead of x <= right-T: no subtraction,
    // and a box thinner than 2*THICK simply has an empty interior.
    assign in_inner = (xe >= le + TK) && (xe + TK <= re) &&
                      (ye >= ue + TK) && (ye + TK <= de);

    assign outline_hit = active && in_outer && !in_inner;
    assign inner_hit   = active && in_inner;

endmodule

// File: rtl/box_overlay_nch.sv
// rtl/box_overlay_nch.sv - N-channel rectangle outline overlay, 2-cycle latency
// Ports: clk, rst_n (async, active-low); per_frame_vsync/href/clken + per_img in;
//        box_valid/box_coord/box_color/box_fill per-box config (sampled on vsync rise);
//        post_frame_vsync/href/clken + post_img out; frame_hit (boxes drawn last frame).
// Optional: define BOX_OVERLAY_FILL_EN to blend box_fill interiors with the box colour.
module box_overlay_nch
    import overlay_pkg::*;
#(
    parameter int IMG_HDISP = 1280,
    parameter int IMG_VDISP = 720,
    parameter int N_BOX     = 10,
    parameter int CW        = 12,
    parameter int THICK     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  per_frame_vsync,
    input  logic                  per_frame_href,
    input  logic                  per_frame_clken,
    input  logic [23:0]           per_img,
    input  logic [N_BOX-1:0]      box_valid,
    input  logic [N_BOX*4*CW-1:0] box_coord,
    input  logic [N_BOX*24-1:0]   box_color,
    input  logic [N_BOX-1:0]      box_fill,
    output logic                  post_frame_vsync,
    output logic                  post_frame_href,
    output logic                  post_frame_clken,
    output logic [23:0]           post_img,
    output logic [N_BOX-1:0]      frame_hit
);

    localparam logic [CW-1:0] X_LAST = CW'(IMG_HDISP - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(IMG_VDISP - 1);

    logic                  vsync_d1, vs_rise;
    logic [CW-1:0]         x, y, x_eff, y_eff;
    logic [N_BOX-1:0]      sh_valid, cur_valid;
    logic [N_BOX*4*CW-1:0] sh_coord, cur_coord;
    logic [N_BOX*24-1:0]   sh_color;
    logic [N_BOX-1:0]      outline_hit, inner_hit, s1_outline, hit_acc, s1_new_hits;
    logic [23:0]           s1_img, pix_next;
    logic                  s1_vs, s1_hs, s1_ce;

    assign vs_rise = per_frame_vsync & ~vsync_d1;

    // The pixel arriving with vs_rise belongs to the new frame: it is (0,0) and
    // is judged against the configuration being captured on this same edge.
    assign x_eff     = vs_rise ? '0 : x;
    assign y_eff     = vs_rise ? '0 : y;
    assign cur_valid = vs_rise ? box_valid : sh_valid;
    assign cur_coord = vs_rise ? box_coord : sh_coord;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d1 <= 1'b0;
            x        <= '0;
            y        <= '0;
            sh_valid <= '0;
            sh_coord <= '0;
            sh_color <= '0;
        end else begin
            vsync_d1 <= per_frame_vsync;
            if (vs_rise) begin
                x        <= '0;
                y        <= '0;
                sh_valid <= box_valid;
                sh_coord <= box_coord;
                sh_color <= box_color;
            end else if (per_frame_clken) begin
                if (x < X_LAST) begin
                    x <= x + CW'(1);
                end else begin
                    x <= '0;
                    if (y < Y_LAST) y <= y + CW'(1);
                end
            end
        end
    end

    for (genvar k = 0; k < N_BOX; k++) begin : g_box
        box_edge_hit #(
            .CW        (CW),
            .IMG_HDISP (IMG_HDISP),
            .IMG_VDISP (IMG_VDISP),
            .THICK     (THICK)
        ) u_hit (
            .valid       (cur_valid[k]),
            .up          (cur_coord[k*4*CW + 3*CW +: CW]),
            .down        (cur_coord[k*4*CW + 2*CW +: CW]),
            .left        (cur_coord[k*4*CW + 1*CW +: CW]),
            .right       (cur_coord[k*4*CW +: CW]),
            .x           (x_eff),
            .y           (y_eff),
            .outline_hit (outline_hit[k]),
            .inner_hit   (inner_hit[k])
        );
    end

`ifdef BOX_OVERLAY_FILL_EN
    logic [N_BOX-1:0] sh_fill, cur_fill, s1_fill;

    assign cur_fill = vs_rise ? box_fill : sh_fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_fill <= '0;
            s1_fill <= '0;
        end else begin
            if (vs_rise) sh_fill <= box_fill;
            s1_fill <= inner_hit & cur_fill;
        end
    end
`else
    logic unused_fill;
    assign unused_fill = ^{box_fill, inner_hit};
`endif

    // Stage 1: per-box hit flags plus the pixel and syncs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_outline <= '0;
            s1_img     <= '0;
            s1_vs      <= 1'b0;
            s1_hs      <= 1'b0;
            s1_ce      <= 1'b0;
        end else begin
            s1_outline <= outline_hit;
            s1_img     <= per_img;
            s1_vs      <= per_frame_vsync;
            s1_hs      <= per_frame_href;
            s1_ce      <= per_frame_clken;
        end
    end

    // Stage 2 priority: walk from the highest index down so the lowest index wins;
    // outlines are applied last so they override any fill.
    always_comb begin
        pix_next = s1_img;
`ifdef BOX_OVERLAY_FILL_EN
        for (int k = N_BOX - 1; k >= 0; k--) begin
            if (s1_fill[k]) pix_next = blend50(s1_img, sh_color[k*24 +: 24]);
        end
`endif
        for (int k = N_BOX - 1; k >= 0; k--) begin
            if (s1_outline[k]) pix_next = sh_color[k*24 +: 24];
        end
    end

    assign s1_new_hits = s1_outline & {N_BOX{s1_ce}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img         <= '0;
            hit_acc          <= '0;
            frame_hit        <= '0;
        end else begin
            post_frame_vsync <= s1_vs;
            post_frame_href  <= s1_hs;
            post_frame_clken <= s1_ce;
            post_img         <= pix_next;
            // A last-frame pixel still in stage 1 at vs_rise is folded into the report.
            if (vs_rise) begin
                frame_hit <= hit_acc | s1_new_hits;
                hit_acc   <= '0;
            end else begin
                hit_acc   <= hit_acc | s1_new_hits;
            end
        end
    end

endmodule

// File: tb/tb_box_overlay_nch.sv
// tb/tb_box_overlay_nch.sv - scoreboard bench for box_overlay_nch
module tb_box_overlay_nch;
    import overlay_pkg::*;

    localparam int HD = 16;
    localparam int VD = 8;
    localparam int NB = 2;
    localparam int CWB = 12;
    localparam int TK = 1;
    localparam logic [23:0] GREY = 24'h808080;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vs = 1'b0, hs = 1'b0, ce = 1'b0;
    logic [23:0] img = '0;
    box_coord_t c [NB];
    logic [23:0] col [NB];
    logic [NB-1:0] val = '0;
    logic [NB-1:0] fil = '0;
    logic [NB*4*CWB-1:0] coord_bus;
    logic [NB*24-1:0] color_bus;

    logic post_vs, post_hs, post_ce;
    logic [23:0] post_img;
    logic [NB-1:0] frame_hit;

    assign coord_bus = {c[1], c[0]};
    assign color_bus = {col[1], col[0]};

    box_overlay_nch #(
        .IMG_HDISP(HD), .IMG_VDISP(VD), .N_BOX(NB), .CW(CWB), .THICK(TK)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vs), .per_frame_href(hs), .per_frame_clken(ce), .per_img(img),
        .box_valid(val), .box_coord(coord_bus), .box_color(color_bus), .box_fill(fil),
        .post_frame_vsync(post_vs), .post_frame_href(post_hs), .post_frame_clken(post_ce),
        .post_img(post_img), .frame_hit(frame_hit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic vs, hs, ce;
        logic [23:0] img;
        bit chk_img;
    } exp_t;
    exp_t q[$];
    exp_t mon_ex;

    // Reference model state
    int m_x, m_y;
    bit m_vsd;
    bit m_sv [NB];
    int m_u [NB], m_d [NB], m_l [NB], m_r [NB];
    logic [23:0] m_col [NB];
    bit m_fill [NB];
    logic [NB-1:0] m_acc = '0, m_fh = '0;

    int rst_hold = 0;
    int mod_line = -1;
    int mod_left = 0;
    int rst_x = -1, rst_y = -1;

    logic [23:0] cap [HD*VD];
    int cap_n = 0;
    logic pv_d = 1'b0;

    function automatic bit m_active(int k);
        return m_sv[k] && m_u[k] <= m_d[k] && m_l[k] <= m_r[k] && m_r[k] < HD && m_d[k] < VD;
    endfunction

    function automatic bit m_outer(int k, int px, int py);
        return px >= m_l[k] && px <= m_r[k] && py >= m_u[k] && py <= m_d[k];
    endfunction

    function automatic bit m_inner(int k, int px, int py);
        return px >= m_l[k] + TK && px <= m_r[k] - TK && py >= m_u[k] + TK && py <= m_d[k] - TK;
    endfunction

    // One clock of stimulus; model expectation pushed in the same cycle.
    task automatic step(input bit v, input bit h, input bit e, input logic [23:0] p);
        exp_t ex;
        bit rise, found;
        @(negedge clk);
        #1;
        if (rst_hold > 0) begin
            rst_n = 1'b0;
            rst_hold--;
        end else begin
            rst_n = 1'b1;
        end
        vs = v; hs = h; ce = e; img = p;
        if (!rst_n) begin
            m_x = 0; m_y = 0; m_vsd = 0; m_acc = '0; m_fh = '0;
            for (int k = 0; k < NB; k++) m_sv[k] = 0;
            ex = '{1'b0, 1'b0, 1'b0, 24'h0, 1'b1};
            if (q.size() > 0) q[$] = ex;
            q.push_back(ex);
        end else begin
            rise = v && !m_vsd;
            if (rise) begin
                m_fh = m_acc; m_acc = '0; m_x = 0; m_y = 0;
                for (int k = 0; k < NB; k++) begin
                    m_sv[k] = val[k]; m_u[k] = int'(c[k].up); m_d[k] = int'(c[k].down);
                    m_l[k] = int'(c[k].left); m_r[k] = int'(c[k].right);
                    m_col[k] = col[k]; m_fill[k] = fil[k];
                end
            end
            ex.vs = v; ex.hs = h; ex.ce = e; ex.chk_img = e; ex.img = p;
            found = 0;
            for (int k = 0; k < NB; k++) begin
                if (!found && m_active(k) && m_outer(k, m_x, m_y) && !m_inner(k, m_x, m_y)) begin
                    ex.img = m_col[k]; found = 1;
                end
            end
`ifdef BOX_OVERLAY_FILL_EN
            for (int k = 0; k < NB; k++) begin
                if (!found && m_active(k) && m_fill[k] && m_inner(k, m_x, m_y)) begin
                    ex.img = ((p >> 1) & 24'h7F7F7F) + ((m_col[k] >> 1) & 24'h7F7F7F);
                    found = 1;
                end
            end
`endif
            for (int k = 0; k < NB; k++)
                if (e && m_active(k) && m_outer(k, m_x, m_y) && !m_inner(k, m_x, m_y)) m_acc[k] = 1'b1;
            if (e && !rise) begin
                if (m_x < HD - 1) m_x++;
                else begin
                    m_x = 0;
                    if (m_y < VD - 1) m_y++;
                end
            end
            m_vsd = v;
            q.push_back(ex);
        end
        @(posedge clk);
    endtask

    // Output side: scoreboard pop plus a frame capture for explicit pixel checks.
    always @(negedge clk) begin
        if (q.size() >= 2) begin
            mon_ex = q.pop_front();
            checks++;
            if (post_vs !== mon_ex.vs || post_hs !== mon_ex.hs || post_ce !== mon_ex.ce ||
                (mon_ex.chk_img && post_img !== mon_ex.img)) begin
                errors++;
                $display("FAIL pixel t=%0t got vs%0b hs%0b ce%0b %06h required vs%0b hs%0b ce%0b %06h",
                         $time, post_vs, post_hs, post_ce, post_img,
                         mon_ex.vs, mon_ex.hs, mon_ex.ce, mon_ex.img);
            end
        end
        if (post_vs && !pv_d) cap_n = 0;
        else if (post_ce && cap_n < HD*VD) begin
            cap[cap_n] = post_img;
            cap_n++;
        end
        pv_d = post_vs;
    end

    task automatic send_frame(input logic [23:0] p);
        step(1, 0, 0, 24'h0);
        #2;
        checks++;
        if (frame_hit !== m_fh) begin
            errors++;
            $display("FAIL frame_hit_at_vsync got %b required %b", frame_hit, m_fh);
        end
        step(1, 0, 0, 24'h0);
        step(0, 0, 0, 24'h0);
        step(0, 0, 0, 24'h0);
        for (int yy = 0; yy < VD; yy++) begin
            step(0, 0, 0, 24'h0);
            #1;
            if (yy == mod_line) c[0].left = CWB'(mod_left);
            step(0, 0, 0, 24'h0);
            for (int xx = 0; xx < HD; xx++) begin
                if (xx == rst_x && yy == rst_y) rst_hold = 6;
                step(0, 1, 1, p);
                if (!rst_n) begin
                    #2;
                    checks++;
                    if (frame_hit !== '0 || post_img !== 24'h0 || post_ce !== 1'b0 ||
                        post_vs !== 1'b0 || post_hs !== 1'b0) begin
                        errors++;
                        $display("FAIL outputs_in_reset got hit %b img %06h ce %b required 0",
                                 frame_hit, post_img, post_ce);
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 24'h0);
    endtask

    task automatic test_reset;
        rst_hold = 3;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 24'h123456);
            #2;
            checks++;
            if (post_vs !== 1'b0 || post_hs !== 1'b0 || post_ce !== 1'b0 ||
                post_img !== 24'h0 || frame_hit !== '0) begin
                errors++;
                $display("FAIL reset_state got vs%b hs%b ce%b img %06h hit %b required 0",
                         post_vs, post_hs, post_ce, post_img, frame_hit);
            end
        end
        step(0, 1, 1, 24'hABCDEF);
        step(0, 1, 1, 24'hABCDEF);
        step(0, 1, 1, 24'hABCDEF);
        #2;
        checks++;
        if (post_img !== 24'hABCDEF || post_ce !== 1'b1) begin
            errors++;
            $display("FAIL passthrough_before_vsync got %06h ce %b required abcdef ce 1", post_img, post_ce);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 24'h0);
    endtask

    task automatic test_single_box;
        int tx [8] = '{3, 10, 3, 6, 4, 2, 11, 10};
        int ty [8] = '{2, 5, 4, 5, 3, 2, 2, 3};
        logic [23:0] te [8] = '{RED, RED, RED, RED, GREY, GREY, GREY, RED};
        c[0] = '{up: 12'd2, down: 12'd5, left: 12'd3, right: 12'd10};
        col[0] = RED;
        val = 2'b01;
        send_frame(GREY);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap[ty[i]*HD + tx[i]] !== te[i]) begin
                errors++;
                $display("FAIL single_box (%0d,%0d) got %06h required %06h",
                         tx[i], ty[i], cap[ty[i]*HD + tx[i]], te[i]);
            end
        end
    endtask

    task automatic test_overlap;
        int tx [4] = '{3, 0, 1, 3};
        int ty [4] = '{2, 2, 4, 3};
        logic [23:0] te [4] = '{RED, WHITE, WHITE, RED};
        c[1] = '{up: 12'd2, down: 12'd4, left: 12'd0, right: 12'd3};
        col[1] = WHITE;
        val = 2'b11;
        send_frame(GREY);
        checks++;
        if (frame_hit !== 2'b01) begin
            errors++;
            $display("FAIL frame_hit_single got %b required 01", frame_hit);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap[ty[i]*HD + tx[i]] !== te[i]) begin
                errors++;
                $display("FAIL overlap (%0d,%0d) got %06h required %06h",
                         tx[i], ty[i], cap[ty[i]*HD + tx[i]], te[i]);
            end
        end
        send_frame(GREY);
        checks++;
        if (frame_hit !== 2'b11) begin
            errors++;
            $display("FAIL frame_hit_overlap got %b required 11", frame_hit);
        end
    endtask

    task automatic test_mid_frame_change;
        int tx [4] = '{3, 3, 6, 6};
        int ty [4] = '{2, 4, 4, 2};
        logic [23:0] old_e [4] = '{RED, RED, GREY, RED};
        logic [23:0] new_e [4] = '{GREY, GREY, RED, RED};
        val = 2'b01;
        mod_line = 4;
        mod_left = 6;
        send_frame(GREY);
        mod_line = -1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap[ty[i]*HD + tx[i]] !== old_e[i]) begin
                errors++;
                $display("FAIL midchange_same_frame (%0d,%0d) got %06h required %06h",
                         tx[i], ty[i], cap[ty[i]*HD + tx[i]], old_e[i]);
            end
        end
        send_frame(GREY);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap[ty[i]*HD + tx[i]] !== new_e[i]) begin
                errors++;
                $display("FAIL midchange_next_frame (%0d,%0d) got %06h required %06h",
                         tx[i], ty[i], cap[ty[i]*HD + tx[i]], new_e[i]);
            end
        end
        c[0].left = 12'd3;
    endtask

    task automatic test_invalid_boxes;
        int tx [5] = '{3, 3, 3, 15, 10};
        int ty [5] = '{2, 5, 6, 3, 2};
        c[0] = '{up: 12'd6, down: 12'd2, left: 12'd3, right: 12'd10};
        c[1] = '{up: 12'd2, down: 12'd5, left: 12'd3, right: 12'd16};
        val = 2'b11;
        send_frame(GREY);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cap[ty[i]*HD + tx[i]] !== GREY) begin
                errors++;
                $display("FAIL invalid_box (%0d,%0d) got %06h required 808080",
                         tx[i], ty[i], cap[ty[i]*HD + tx[i]]);
            end
        end
        send_frame(GREY);
        checks++;
        if (frame_hit !== 2'b00) begin
            errors++;
            $display("FAIL frame_hit_invalid got %b required 00", frame_hit);
        end
    endtask

    task automatic test_reset_mid_frame;
        c[0] = '{up: 12'd2, down: 12'd5, left: 12'd3, right: 12'd10};
        val = 2'b01;
        rst_x = 7;
        rst_y = 3;
        send_frame(GREY);
        rst_x = -1;
        rst_y = -1;
        send_frame(GREY);
        checks++;
        if (frame_hit !== 2'b00) begin
            errors++;
            $display("FAIL frame_hit_after_reset got %b required 00", frame_hit);
        end
        checks++;
        if (cap[2*HD + 3] !== RED || cap[5*HD + 10] !== RED || cap[3*HD + 5] !== GREY) begin
            errors++;
            $display("FAIL boxes_after_reset got %06h %06h %06h required ff0000 ff0000 808080",
                     cap[2*HD + 3], cap[5*HD + 10], cap[3*HD + 5]);
        end
    endtask

`ifdef BOX_OVERLAY_FILL_EN
    task automatic test_fill;
        int tx [5] = '{5, 4, 3, 3, 11};
        int ty [5] = '{3, 3, 2, 3, 3};
        logic [23:0] te [5] = '{24'h407F00, 24'h407F00, 24'h00FF00, 24'h00FF00, 24'h800000};
        c[0] = '{up: 12'd2, down: 12'd5, left: 12'd3, right: 12'd10};
        col[0] = 24'h00FF00;
        val = 2'b01;
        fil = 2'b01;
        send_frame(24'h800000);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cap[ty[i]*HD + tx[i]] !== te[i]) begin
                errors++;
                $display("FAIL fill (%0d,%0d) got %06h required %06h",
                         tx[i], ty[i], cap[ty[i]*HD + tx[i]], te[i]);
            end
        end
        fil = 2'b00;
    endtask
`endif

    initial begin
        for (int k = 0; k < NB; k++) begin
            c[k] = '0;
            col[k] = 24'h0;
            m_sv[k] = 0;
            m_fill[k] = 0;
        end
        m_x = 0; m_y = 0; m_vsd = 0;
        test_reset();
        test_single_box();
        test_overlap();
        test_mid_frame_change();
        test_invalid_boxes();
        test_reset_mid_frame();
`ifdef BOX_OVERLAY_FILL_EN
        test_fill();
`endif
        for (int i = 0; i < 4; i++) step(0, 0, 0, 24'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
